// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Receives one asynchronous serial frame per start pulse: start bit,
// DATA_BITS data bits LSB first, optional even parity bit, stop bit.
// The payload of each good frame lands in a valid/ready output register.
//
// Optional feature: define SERIAL_RX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit and to add the parity_err output.
//
// Output handshake: data_valid high means data_out holds a word the consumer
// has not yet taken; the word is taken on any rising clk edge where
// data_valid && data_ready, and data_valid drops the following cycle unless
// a new good frame is loaded on that same edge, in which case the new word
// replaces the old one and data_valid stays high.
module serial_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 frame_err,
`ifdef SERIAL_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // req arrives one cycle after the line falls, so the start-bit centre
    // is reached two counts earlier than a plain half-bit count.
    localparam logic [CNT_W-1:0] START_SAMPLE = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    logic start_tick;
    logic data_tick;
    logic stop_tick;
    logic last_data;
    logic sample_tick;
    logic state_change;
    logic stop_good;
    logic accept;

`ifdef SERIAL_RX_PARITY_EN
    logic par_tick;
    logic par_acc;
    logic par_bad;
`endif

    // Sample strobes: one per bit, taken at the bit-specific count value.
    always_comb begin
        start_tick = (state == S_START) && (cnt == START_SAMPLE);
        data_tick  = (state == S_DATA)  && (cnt == BIT_LAST);
        stop_tick  = (state == S_STOP)  && (cnt == BIT_LAST);
        last_data  = data_tick && (bit_idx == IDX_LAST);
        accept     = data_valid && data_ready;
`ifdef SERIAL_RX_PARITY_EN
        par_tick    = (state == S_PARITY) && (cnt == BIT_LAST);
        sample_tick = start_tick || data_tick || par_tick || stop_tick;
        stop_good   = stop_tick && serial_in && !par_bad;
`else
        sample_tick = start_tick || data_tick || stop_tick;
        stop_good   = stop_tick && serial_in;
`endif
    end

    // Next-state decode for the frame sequencer.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (start_tick) begin
                    // A high line at the start-bit centre is a glitch.
                    state_next = serial_in ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (last_data) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (par_tick) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (stop_tick) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        state_change = (state_next != state);
    end

    // State register; req is only looked at from IDLE, so pulses mid-frame are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Cycle counter within the current bit, restarted at every sample and state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_change || sample_tick) begin
            cnt <= '0;
        end else if (state != S_IDLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Data bit index: cleared when the start bit is confirmed, bumped per data sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
        end else if (start_tick) begin
            bit_idx <= '0;
        end else if (data_tick) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // Shift register fills from the MSB side so the first bit ends up at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (data_tick) begin
            shreg <= {serial_in, shreg[DATA_BITS-1:1]};
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    // Running even parity over the data bits, judged when the parity bit is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_acc <= 1'b0;
            par_bad <= 1'b0;
        end else if (start_tick) begin
            par_acc <= 1'b0;
            par_bad <= 1'b0;
        end else if (data_tick) begin
            par_acc <= par_acc ^ serial_in;
        end else if (par_tick) begin
            par_bad <= par_acc ^ serial_in;
        end
    end

    // Parity error pulse is issued together with the stop-bit sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= stop_tick && par_bad;
        end
    end
`endif

    // Output register: load on a good stop bit, otherwise drain on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_tick && !serial_in;
            if (stop_good) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                if (data_valid && !data_ready) begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
// Drives serial frames (directed cases, then random ones) into
// serial_frame_rx and checks every cycle against a bit-timing model.
// Define SERIAL_RX_PARITY_EN to build against the parity variant.
module tb_serial_frame_rx;

    localparam int C  = 4;
    localparam int D  = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = D + 2 + PB;

    // Clock and reset block
    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic req        = 1'b0;
    logic serial_in  = 1'b1;
    logic data_ready = 1'b0;

    logic [D-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;
`ifdef SERIAL_RX_PARITY_EN
    logic         parity_err;
`endif

    always #5 clk = ~clk;

    serial_frame_rx #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .serial_in (serial_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .busy      (busy),
        .frame_err (frame_err),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    int   total      = 0;
    int   bad        = 0;
    int   cyc        = 0;
    int   ready_mode = 0;
    logic chk_en     = 1'b0;

    // Reference model state
    logic [D-1:0] m_data    = '0;
    logic [D-1:0] m_sh      = '0;
    logic         m_dv      = 1'b0;
    logic         m_fe      = 1'b0;
    logic         m_pe      = 1'b0;
    logic         m_ovr     = 1'b0;
    logic         m_active  = 1'b0;
    logic         m_par_bad = 1'b0;
    int           m_e       = 0;

    int   last_req_cyc = 0;
    int   lat_meas     = -1;
    int   fe_count     = 0;
    int   pe_count     = 0;
    logic prev_dv      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each frame is timed from the edge that accepted req. The start
    // bit is judged C/2-1 edges later, then every C edges one wire bit
    // (data bits, optional parity, stop) is sampled.
    always @(posedge clk) begin : model
        int   r;
        int   slot;
        logic load;
        cyc  = cyc + 1;
        load = 1'b0;
        m_fe = 1'b0;
        m_pe = 1'b0;
        if (req) last_req_cyc = cyc;
        if (rst) begin
            m_data    = '0;
            m_dv      = 1'b0;
            m_ovr     = 1'b0;
            m_active  = 1'b0;
            m_par_bad = 1'b0;
        end else begin
            if (m_active) begin
                r = cyc - m_e;
                if (r == C / 2 - 1) begin
                    if (serial_in) m_active = 1'b0;
                end else if (r > C / 2 - 1 && ((r - (C / 2 - 1)) % C) == 0) begin
                    slot = (r - (C / 2 - 1)) / C;
                    if (slot <= D) begin
                        m_sh[slot-1] = serial_in;
                    end else if (PB == 1 && slot == D + 1) begin
                        m_par_bad = (^m_sh) ^ serial_in;
                    end else begin
                        m_active = 1'b0;
                        m_fe     = ~serial_in;
                        m_pe     = (PB == 1) && m_par_bad;
                        load     = serial_in && !m_pe;
                    end
                end
            end else if (req) begin
                m_active  = 1'b1;
                m_e       = cyc;
                m_par_bad = 1'b0;
            end
            if (load) begin
                if (m_dv && !data_ready) m_ovr = 1'b1;
                m_data = m_sh;
                m_dv   = 1'b1;
            end else if (m_dv && data_ready) begin
                m_dv = 1'b0;
            end
        end
    end

    // Scoreboard compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_valid", 32'(data_valid), 32'(m_dv));
            chk("data_out",   32'(data_out),   32'(m_data));
            chk("frame_err",  32'(frame_err),  32'(m_fe));
            chk("overrun",    32'(overrun),    32'(m_ovr));
            chk("busy",       32'(busy),       32'(m_active));
`ifdef SERIAL_RX_PARITY_EN
            chk("parity_err", 32'(parity_err), 32'(m_pe));
`endif
        end
        if (data_valid === 1'b1 && prev_dv !== 1'b1) lat_meas = cyc - last_req_cyc;
        prev_dv = data_valid;
        if (frame_err === 1'b1) fe_count = fe_count + 1;
`ifdef SERIAL_RX_PARITY_EN
        if (parity_err === 1'b1) pe_count = pe_count + 1;
`endif
    end

    // Driver tasks
    task automatic drive_cycle(input logic s, input logic rq, input logic rs, input logic force_rdy);
        @(negedge clk);
        serial_in = s;
        req       = rq;
        rst       = rs;
        if (force_rdy) data_ready = 1'b1;
        else if (ready_mode == 0) data_ready = 1'b0;
        else if (ready_mode == 1) data_ready = 1'b1;
        else data_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic glitch();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [D-1:0] d, input logic stop_bit, input logic par_flip,
                              input logic extra_req, input int rst_bit, input logic accept_at_stop);
        logic [NB-1:0] bits;
        bits[0] = 1'b0;
        for (int i = 0; i < D; i++) bits[i+1] = d[i];
        bits[D+1]  = (^d) ^ par_flip;
        bits[NB-1] = stop_bit;
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < C; j++) begin
                drive_cycle(bits[b],
                            (b == 0 && j == 1) || (extra_req && b >= 1 && b <= D && j == 2),
                            (b == rst_bit && j == 0),
                            accept_at_stop && b == NB - 1 && j == C / 2);
            end
        end
    endtask

    initial begin
        #1_000_000;
        bad = bad + 1;
        $display("FAIL watchdog actual=running required=finished time=%0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D-1:0] d;
        ready_mode = 0;
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("reset_data_valid", 32'(data_valid), 32'd0);
        chk("reset_data_out",   32'(data_out),   32'd0);
        chk("reset_busy",       32'(busy),       32'd0);
        chk("reset_frame_err",  32'(frame_err),  32'd0);
        chk("reset_overrun",    32'(overrun),    32'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;

        // 0xA5, consumer not ready: word holds until accepted
        lat_meas = -1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        idle(2);
        chk("a5_valid",   32'(data_valid), 32'd1);
        chk("a5_data",    32'(data_out),   32'h0A5);
        chk("a5_ferr",    32'(fe_count),   32'd0);
        chk("a5_latency", 32'(lat_meas),   (PB == 1) ? 32'd41 : 32'd37);
        idle(5);
        chk("a5_hold",    32'(data_valid), 32'd1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("a5_accept",  32'(data_valid), 32'd0);

        // Glitch on the line: false start
        glitch();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("glitch_busy_lo", 32'(busy), 32'd0);
        idle(3);
        chk("glitch_valid", 32'(data_valid), 32'd0);
        chk("glitch_ferr",  32'(fe_count),   32'd0);

        // 0x3C with a low stop bit
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        idle(3);
        chk("ferr_count", 32'(fe_count),   32'd1);
        chk("ferr_data",  32'(data_out),   32'h0A5);
        chk("ferr_valid", 32'(data_valid), 32'd0);

        // Back-to-back 0x11, 0x22 with no consumer
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        idle(2);
        chk("b2b_data",    32'(data_out),   32'h022);
        chk("b2b_overrun", 32'(overrun),    32'd1);
        chk("b2b_valid",   32'(data_valid), 32'd1);
        repeat (2) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_clears_overrun", 32'(overrun), 32'd0);

        // Same pair, consumer accepts on the second load edge
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1, 1'b1);
        idle(2);
        chk("b2b_acc_overrun", 32'(overrun),    32'd0);
        chk("b2b_acc_valid",   32'(data_valid), 32'd1);
        chk("b2b_acc_data",    32'(data_out),   32'h022);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);

        // 0x5A with extra req pulses during the data bits
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        idle(2);
        chk("extra_req_data",  32'(data_out),   32'h05A);
        chk("extra_req_valid", 32'(data_valid), 32'd1);
        chk("extra_req_ferr",  32'(fe_count),   32'd1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);

        // Reset during data bit 4, then a clean 0xFF
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 5, 1'b0);
        idle(2);
        chk("abort_valid", 32'(data_valid), 32'd0);
        chk("abort_busy",  32'(busy),       32'd0);
        chk("abort_data",  32'(data_out),   32'd0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        idle(2);
        chk("after_abort_data",  32'(data_out),   32'h0FF);
        chk("after_abort_valid", 32'(data_valid), 32'd1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);

`ifdef SERIAL_RX_PARITY_EN
        // 0x01 with parity bit 0 (odd total)
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        idle(2);
        chk("parity_pulses", 32'(pe_count),   32'd1);
        chk("parity_valid",  32'(data_valid), 32'd0);
        chk("parity_ferr",   32'(fe_count),   32'd1);
`endif

        // Random frames against the model
        for (int n = 0; n < 150; n++) begin
            d = D'($urandom);
            ready_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) begin
                glitch();
            end else begin
                send_frame(d,
                           1'($urandom_range(0, 7) != 0),
                           1'((PB == 1) && ($urandom_range(0, 5) == 0)),
                           1'($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, D)) : -1,
                           1'($urandom_range(0, 3) == 0));
            end
            idle($urandom_range(0, 4));
        end
        idle(5);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
